// File: rtl/mips_cpu_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - state_t  : 4-bit FSM state encoding (also exported on state_o)
//   - aluop_t  : ALU function encodings driven on aluop
//   - opcode / fncode constants for the supported instruction subset
//   - pcsource / alusrcb selector constants
//   - is_muldiv: identifies the R-type multi-cycle multiply/divide group
// ---------------------------------------------------------------------------
package mips_cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_EXEC_MD  = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    // True for the R-type functions that occupy the external mult/div unit
    // and therefore park the FSM in the EXEC_MD wait state.
    function automatic logic is_muldiv(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) ||
               (fn == FN_DIV)  || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/mips_cpu_alu_decode.sv
// ---------------------------------------------------------------------------
// mips_cpu_alu_decode
// Purely combinational ALU function decoder shared by the R-type and
// I-type execute states.
//   opcode_i : IR[31:26]
//   fncode_i : IR[5:0], only meaningful when opcode_i is R-type
//   aluop_o  : ALU function (aluop_t)
// Anything without an arithmetic meaning of its own (ADDU, JR, mult/div,
// unknown codes) falls back to ALU_ADD.
// ---------------------------------------------------------------------------
module mips_cpu_alu_decode
    import mips_cpu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] fncode_i,
    output aluop_t     aluop_o
);

    // R-type takes its function from fncode; immediates take it from the
    // opcode. Variable shifts share the ALU shifter with the fixed ones.
    always_comb begin
        aluop_o = ALU_ADD;
        if (opcode_i == OP_RTYPE) begin
            case (fncode_i)
                FN_SUB, FN_SUBU:  aluop_o = ALU_SUB;
                FN_AND:           aluop_o = ALU_AND;
                FN_OR:            aluop_o = ALU_OR;
                FN_XOR:           aluop_o = ALU_XOR;
                FN_NOR:           aluop_o = ALU_NOR;
                FN_SLT:           aluop_o = ALU_SLT;
                FN_SLTU:          aluop_o = ALU_SLTU;
                FN_SLL, FN_SLLV:  aluop_o = ALU_SLL;
                FN_SRL, FN_SRLV:  aluop_o = ALU_SRL;
                FN_SRA, FN_SRAV:  aluop_o = ALU_SRA;
                default:          aluop_o = ALU_ADD;
            endcase
        end else begin
            case (opcode_i)
                OP_SLTI:  aluop_o = ALU_SLT;
                OP_SLTIU: aluop_o = ALU_SLTU;
                OP_ANDI:  aluop_o = ALU_AND;
                OP_ORI:   aluop_o = ALU_OR;
                OP_XORI:  aluop_o = ALU_XOR;
                OP_LUI:   aluop_o = ALU_LUI;
                default:  aluop_o = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mips_cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// mips_cpu_control_fsm
// Sequenced control unit for the multicycle MIPS core. Owns the state
// register and drives every datapath strobe as a Moore decode of the
// current state (plus opcode/fncode in execute states).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   opcode, fncode        : instruction register fields
//   zero                  : ALU zero flag for BEQ/BNE
//   jr_target_zero        : rs == 0, halts the core on JR
//   mem_waitrequest       : memory stall for FETCH / MEM_RD / MEM_WR
//   regdst .. alusrcb     : datapath mux selects and enables
//   md_start              : one-cycle start pulse to the mult/div unit
//   active                : low once HALT has been entered
//   state_o               : current state for debug
// ---------------------------------------------------------------------------
module mips_cpu_control_fsm
    import mips_cpu_pkg::*;
#(
    parameter int ALUOP_W       = 4,
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         fncode,
    input  logic               zero,
    input  logic               jr_target_zero,
    input  logic               mem_waitrequest,
    output logic               regdst,
    output logic               regwrite,
    output logic               iord,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               pcwritecond,
    output logic [1:0]         pcsource,
    output logic               memread,
    output logic               memwrite,
    output logic               memtoreg,
    output logic [ALUOP_W-1:0] aluop,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic               md_start,
    output logic               active,
    output logic [3:0]         state_o
);

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    aluop_t           dec_aluop;
    aluop_t           aluop_sel;

    mips_cpu_alu_decode u_alu_decode (
        .opcode_i (opcode),
        .fncode_i (fncode),
        .aluop_o  (dec_aluop)
    );

    // State and mult/div countdown registers; reset wins over any stall or
    // pending countdown so the core always restarts cleanly at FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode. While reset is high the case is skipped
    // so every strobe stays at its inactive default.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        iord        = 1'b0;
        irwrite     = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        pcsource    = PCSRC_ALU;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        aluop_sel   = ALU_ADD;
        alusrca     = 1'b0;
        alusrcb     = SRCB_REG;
        md_start    = 1'b0;
        active      = 1'b1;

        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = SRCB_FOUR;
                    if (!mem_waitrequest) begin
                        irwrite = 1'b1;
                        pcwrite = 1'b1;
                        state_d = S_DECODE;
                    end
                end

                S_DECODE: begin
                    alusrcb = SRCB_IMM_SH2;
                    case (opcode)
                        OP_RTYPE: begin
                            if (is_muldiv(fncode)) begin
                                state_d = S_EXEC_MD;
                                cnt_d   = MD_LOAD;
                            end else begin
                                state_d = S_EXEC_R;
                            end
                        end
                        OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                        OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                        OP_J, OP_JAL:    state_d = S_JUMP;
                        OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
                        OP_SLTI, OP_SLTIU, OP_LUI:
                                         state_d = S_EXEC_I;
                        default:         state_d = S_FETCH;
                    endcase
                end

                S_EXEC_R: begin
                    alusrca   = 1'b1;
                    aluop_sel = dec_aluop;
                    if (fncode == FN_JR) begin
                        pcsource = PCSRC_RS;
                        pcwrite  = 1'b1;
                        state_d  = jr_target_zero ? S_HALT : S_FETCH;
                    end else begin
                        state_d = S_WB_R;
                    end
                end

                S_WB_R: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                    state_d  = S_FETCH;
                end

                S_EXEC_I: begin
                    alusrca   = 1'b1;
                    alusrcb   = SRCB_IMM;
                    aluop_sel = dec_aluop;
                    state_d   = S_WB_I;
                end

                S_WB_I: begin
                    regwrite = 1'b1;
                    state_d  = S_FETCH;
                end

                // The counter is loaded on entry, so it equals MD_LOAD only
                // on the first EXEC_MD cycle; that is where md_start fires.
                S_EXEC_MD: begin
                    md_start = (cnt_q == MD_LOAD);
                    if (cnt_q == '0) begin
                        state_d = S_FETCH;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end

                S_MEM_ADDR: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                    if (opcode == OP_LW) begin
                        state_d = S_MEM_RD;
                    end else if (opcode == OP_SW) begin
                        state_d = S_MEM_WR;
                    end else begin
                        state_d = S_FETCH;
                    end
                end

                S_MEM_RD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                    if (!mem_waitrequest) begin
                        state_d = S_MEM_WB;
                    end
                end

                S_MEM_WB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                    state_d  = S_FETCH;
                end

                S_MEM_WR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                    if (!mem_waitrequest) begin
                        state_d = S_FETCH;
                    end
                end

                S_BRANCH: begin
                    alusrca     = 1'b1;
                    aluop_sel   = ALU_SUB;
                    pcsource    = PCSRC_ALUOUT;
                    pcwritecond = (opcode == OP_BNE) ? ~zero : zero;
                    state_d     = S_FETCH;
                end

                // JAL's link into r31 is steered by the datapath; the
                // control unit only has to enable the register write.
                S_JUMP: begin
                    pcsource = PCSRC_JUMP;
                    pcwrite  = 1'b1;
                    regwrite = (opcode == OP_JAL);
                    state_d  = S_FETCH;
                end

                S_HALT: begin
                    active = 1'b0;
                end

                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign aluop   = ALUOP_W'(aluop_sel);
    assign state_o = state_q;

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_control_fsm
// Self-checking bench for the multicycle control FSM: a directed vector
// table measured from the DUT, hand-written corner sequences, and a random
// instruction stream checked cycle by cycle against an instruction-level
// reference model.
// ---------------------------------------------------------------------------
module tb_mips_cpu_control_fsm;
    import mips_cpu_pkg::*;

    localparam int MDC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, fncode;
    logic       zero, jr_target_zero, mem_waitrequest;

    logic       regdst, regwrite, iord, irwrite, pcwrite, pcwritecond;
    logic [1:0] pcsource, alusrcb;
    logic       memread, memwrite, memtoreg, alusrca, md_start, active;
    logic [3:0] aluop, state_o;

    logic       regdst1, regwrite1, iord1, irwrite1, pcwrite1, pcwritecond1;
    logic [1:0] pcsource1, alusrcb1;
    logic       memread1, memwrite1, memtoreg1, alusrca1, md_start1, active1;
    logic [3:0] aluop1, state1;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       regdst;
        logic       regwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       pcwritecond;
        logic [1:0] pcsource;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic [3:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       md_start;
        logic       active;
    } obs_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         memWait;
        int         expCycles;
        logic [2:0] expWr;
        int         expMd;
    } vec_t;

    obs_t act;
    vec_t tbl[$];

    mips_cpu_control_fsm #(.ALUOP_W(4), .MULDIV_CYCLES(MDC), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .fncode(fncode), .zero(zero),
        .jr_target_zero(jr_target_zero), .mem_waitrequest(mem_waitrequest),
        .regdst(regdst), .regwrite(regwrite), .iord(iord), .irwrite(irwrite),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .pcsource(pcsource),
        .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg), .aluop(aluop),
        .alusrca(alusrca), .alusrcb(alusrcb), .md_start(md_start), .active(active),
        .state_o(state_o)
    );

    mips_cpu_control_fsm #(.ALUOP_W(4), .MULDIV_CYCLES(1), .CNT_W(6)) dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .fncode(fncode), .zero(zero),
        .jr_target_zero(jr_target_zero), .mem_waitrequest(mem_waitrequest),
        .regdst(regdst1), .regwrite(regwrite1), .iord(iord1), .irwrite(irwrite1),
        .pcwrite(pcwrite1), .pcwritecond(pcwritecond1), .pcsource(pcsource1),
        .memread(memread1), .memwrite(memwrite1), .memtoreg(memtoreg1), .aluop(aluop1),
        .alusrca(alusrca1), .alusrcb(alusrcb1), .md_start(md_start1), .active(active1),
        .state_o(state1)
    );

    always #5 clk = ~clk;

    assign act = {state_o, regdst, regwrite, iord, irwrite, pcwrite, pcwritecond,
                  pcsource, memread, memwrite, memtoreg, aluop, alusrca, alusrcb,
                  md_start, active};

    // ALU function each instruction needs, written straight from the ISA.
    function automatic logic [3:0] refAlu(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_RTYPE) begin
            if (fn inside {FN_SUB, FN_SUBU}) return ALU_SUB;
            if (fn == FN_AND) return ALU_AND;
            if (fn == FN_OR)  return ALU_OR;
            if (fn == FN_XOR) return ALU_XOR;
            if (fn == FN_NOR) return ALU_NOR;
            if (fn == FN_SLT) return ALU_SLT;
            if (fn == FN_SLTU) return ALU_SLTU;
            if (fn inside {FN_SLL, FN_SLLV}) return ALU_SLL;
            if (fn inside {FN_SRL, FN_SRLV}) return ALU_SRL;
            if (fn inside {FN_SRA, FN_SRAV}) return ALU_SRA;
            return ALU_ADD;
        end
        if (op == OP_SLTI)  return ALU_SLT;
        if (op == OP_SLTIU) return ALU_SLTU;
        if (op == OP_ANDI)  return ALU_AND;
        if (op == OP_ORI)   return ALU_OR;
        if (op == OP_XORI)  return ALU_XOR;
        if (op == OP_LUI)   return ALU_LUI;
        return ALU_ADD;
    endfunction

    // Quiet outputs for a state: no strobes, selectors at zero, ALU adding.
    function automatic obs_t base(input state_t s);
        obs_t e;
        e        = '0;
        e.st     = s;
        e.aluop  = ALU_ADD;
        e.active = 1'b1;
        return e;
    endfunction

    // Outputs required in one state for the instruction being executed.
    function automatic obs_t model(input state_t s, input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input logic w, input logic first);
        obs_t e;
        e = base(s);
        case (s)
            S_FETCH:    begin e.memread = 1'b1; e.alusrcb = 2'd1; e.irwrite = !w; e.pcwrite = !w; end
            S_DECODE:   e.alusrcb = 2'd3;
            S_EXEC_R:   begin
                e.alusrca = 1'b1; e.aluop = refAlu(op, fn);
                if (fn == FN_JR) begin e.pcwrite = 1'b1; e.pcsource = 2'd3; end
            end
            S_WB_R:     begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            S_EXEC_I:   begin e.alusrca = 1'b1; e.alusrcb = 2'd2; e.aluop = refAlu(op, fn); end
            S_WB_I:     e.regwrite = 1'b1;
            S_EXEC_MD:  e.md_start = first;
            S_MEM_ADDR: begin e.alusrca = 1'b1; e.alusrcb = 2'd2; end
            S_MEM_RD:   begin e.memread = 1'b1; e.iord = 1'b1; end
            S_MEM_WB:   begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            S_MEM_WR:   begin e.memwrite = 1'b1; e.iord = 1'b1; end
            S_BRANCH:   begin
                e.alusrca = 1'b1; e.aluop = ALU_SUB; e.pcsource = 2'd1;
                e.pcwritecond = (op == OP_BEQ) ? z : !z;
            end
            S_JUMP:     begin e.pcsource = 2'd2; e.pcwrite = 1'b1; e.regwrite = (op == OP_JAL); end
            S_HALT:     e.active = 1'b0;
            default:    e = base(s);
        endcase
        return e;
    endfunction

    // Drive the instruction and side inputs.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic jrz, input logic w);
        opcode          = op;
        fncode          = fn;
        zero            = z;
        jr_target_zero  = jrz;
        mem_waitrequest = w;
    endtask

    // Compare the whole observed output bundle with the expected one.
    task automatic checkOutput(input obs_t e, input string name);
        total++;
        if (act !== e) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h (state got %0d want %0d)",
                     name, act, e, act.st, e.st);
        end
    endtask

    task automatic checkVal(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    // Check at the falling edge, then advance one clock.
    task automatic stepCheck(input obs_t e, input string name);
        @(negedge clk);
        checkOutput(e, name);
        @(posedge clk);
        #1;
    endtask

    // One reset cycle from a known state, checked, then released.
    task automatic doReset(input state_t cur);
        reset           = 1'b1;
        mem_waitrequest = 1'($urandom_range(0, 1));
        stepCheck(base(cur), "reset_cycle");
        reset           = 1'b0;
        mem_waitrequest = 1'b0;
    endtask

    // Reference model: walks one instruction through its state sequence.
    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input logic jrz, input int fw, input int mw, output bit halted);
        halted = 1'b0;
        applyStimulus(op, fn, z, jrz, 1'b0);
        for (int i = 0; i <= fw; i++) begin
            mem_waitrequest = (i < fw);
            stepCheck(model(S_FETCH, op, fn, z, (i < fw), 1'b0), "fetch");
        end
        mem_waitrequest = 1'($urandom_range(0, 1));
        stepCheck(model(S_DECODE, op, fn, z, 1'b0, 1'b0), "decode");
        if (op == OP_RTYPE) begin
            if (fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU}) begin
                for (int k = 0; k < MDC; k++)
                    stepCheck(model(S_EXEC_MD, op, fn, z, 1'b0, (k == 0)), "exec_md");
            end else begin
                stepCheck(model(S_EXEC_R, op, fn, z, 1'b0, 1'b0), "exec_r");
                if (fn == FN_JR) halted = jrz;
                else stepCheck(model(S_WB_R, op, fn, z, 1'b0, 1'b0), "wb_r");
            end
        end else if (op == OP_LW || op == OP_SW) begin
            stepCheck(model(S_MEM_ADDR, op, fn, z, 1'b0, 1'b0), "mem_addr");
            for (int i = 0; i <= mw; i++) begin
                mem_waitrequest = (i < mw);
                stepCheck(model((op == OP_LW) ? S_MEM_RD : S_MEM_WR, op, fn, z, 1'b0, 1'b0), "mem_access");
            end
            if (op == OP_LW) begin
                mem_waitrequest = 1'($urandom_range(0, 1));
                stepCheck(model(S_MEM_WB, op, fn, z, 1'b0, 1'b0), "mem_wb");
            end
        end else if (op == OP_BEQ || op == OP_BNE) begin
            stepCheck(model(S_BRANCH, op, fn, z, 1'b0, 1'b0), "branch");
        end else if (op == OP_J || op == OP_JAL) begin
            stepCheck(model(S_JUMP, op, fn, z, 1'b0, 1'b0), "jump");
        end else if (op inside {OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI}) begin
            stepCheck(model(S_EXEC_I, op, fn, z, 1'b0, 1'b0), "exec_i");
            stepCheck(model(S_WB_I, op, fn, z, 1'b0, 1'b0), "wb_i");
        end
        mem_waitrequest = 1'b0;
    endtask

    // Runs one table vector, measuring cycle count and strobes from the DUT.
    task automatic runVector(input vec_t v);
        int         cyc, stall, md;
        logic [2:0] wr;
        cyc = 0; stall = 0; md = 0; wr = '0;
        applyStimulus(v.op, v.fn, v.z, 1'b0, 1'b0);
        do begin
            @(negedge clk);
            if ((state_o == S_MEM_RD || state_o == S_MEM_WR) && stall < v.memWait) begin
                mem_waitrequest = 1'b1;
                stall++;
            end else begin
                mem_waitrequest = 1'b0;
            end
            #1;
            wr = wr | {regwrite, memwrite, pcwritecond};
            md += int'(md_start);
            @(posedge clk);
            #1;
            cyc++;
        end while (state_o != S_FETCH && cyc < 40);
        mem_waitrequest = 1'b0;
        checkVal({v.name, "_cycles"}, cyc, v.expCycles);
        checkVal({v.name, "_writes"}, int'(wr), int'(v.expWr));
        checkVal({v.name, "_md_pulses"}, md, v.expMd);
    endtask

    initial begin
        logic [5:0] ops[$];
        logic [5:0] fns[$];
        bit         halted;
        int         run1, md1;
        bit         done1;

        tbl.push_back('{"addu",   OP_RTYPE, FN_ADDU,  1'b0, 0, 4, 3'b100, 0});
        tbl.push_back('{"lw_w3",  OP_LW,    6'h00,    1'b0, 3, 8, 3'b100, 0});
        tbl.push_back('{"sw_w2",  OP_SW,    6'h00,    1'b0, 2, 6, 3'b010, 0});
        tbl.push_back('{"beq_z1", OP_BEQ,   6'h00,    1'b1, 0, 3, 3'b001, 0});
        tbl.push_back('{"beq_z0", OP_BEQ,   6'h00,    1'b0, 0, 3, 3'b000, 0});
        tbl.push_back('{"bne_z0", OP_BNE,   6'h00,    1'b0, 0, 3, 3'b001, 0});
        tbl.push_back('{"bne_z1", OP_BNE,   6'h00,    1'b1, 0, 3, 3'b000, 0});
        tbl.push_back('{"j",      OP_J,     6'h00,    1'b0, 0, 3, 3'b000, 0});
        tbl.push_back('{"jal",    OP_JAL,   6'h00,    1'b0, 0, 3, 3'b100, 0});
        tbl.push_back('{"addiu",  OP_ADDIU, 6'h00,    1'b0, 0, 4, 3'b100, 0});
        tbl.push_back('{"mult",   OP_RTYPE, FN_MULT,  1'b0, 0, 6, 3'b000, 1});
        tbl.push_back('{"divu",   OP_RTYPE, FN_DIVU,  1'b0, 0, 6, 3'b000, 1});
        tbl.push_back('{"illegal",6'h3f,    6'h00,    1'b0, 0, 2, 3'b000, 0});
        tbl.push_back('{"jr_nz",  OP_RTYPE, FN_JR,    1'b0, 0, 3, 3'b000, 0});

        $display("[TB] start");
        reset = 1'b1;
        applyStimulus(6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        stepCheck(base(S_FETCH), "reset_state");
        reset = 1'b0;

        foreach (tbl[i]) runVector(tbl[i]);

        // LW with a three-cycle read stall, checked every cycle.
        runInstr(OP_LW, 6'h00, 1'b0, 1'b0, 0, 3, halted);

        // Reset arriving in the middle of a store stall.
        applyStimulus(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0);
        stepCheck(model(S_FETCH, OP_SW, 6'h00, 1'b0, 1'b0, 1'b0), "sw_fetch");
        stepCheck(model(S_DECODE, OP_SW, 6'h00, 1'b0, 1'b0, 1'b0), "sw_decode");
        stepCheck(model(S_MEM_ADDR, OP_SW, 6'h00, 1'b0, 1'b0, 1'b0), "sw_addr");
        mem_waitrequest = 1'b1;
        stepCheck(model(S_MEM_WR, OP_SW, 6'h00, 1'b0, 1'b1, 1'b0), "sw_stall");
        reset = 1'b1;
        stepCheck(base(S_MEM_WR), "reset_in_stall");
        reset = 1'b0;
        stepCheck(model(S_FETCH, OP_SW, 6'h00, 1'b0, 1'b1, 1'b0), "fetch_after_reset");
        mem_waitrequest = 1'b0;
        stepCheck(model(S_FETCH, OP_SW, 6'h00, 1'b0, 1'b0, 1'b0), "sw2_fetch");
        stepCheck(model(S_DECODE, OP_SW, 6'h00, 1'b0, 1'b0, 1'b0), "sw2_decode");
        stepCheck(model(S_MEM_ADDR, OP_SW, 6'h00, 1'b0, 1'b0, 1'b0), "sw2_addr");
        stepCheck(model(S_MEM_WR, OP_SW, 6'h00, 1'b0, 1'b0, 1'b0), "sw2_write");

        // JR to address zero halts and stays quiet whatever the inputs do.
        runInstr(OP_RTYPE, FN_JR, 1'b0, 1'b1, 0, 0, halted);
        checkVal("jr_zero_halts", int'(halted), 1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            stepCheck(model(S_HALT, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0), "halt_quiet");
        end
        doReset(S_HALT);

        // Single-cycle mult/div instance: exactly one EXEC_MD cycle, one pulse.
        applyStimulus(OP_RTYPE, FN_MULT, 1'b0, 1'b0, 1'b0);
        run1 = 0; md1 = 0; done1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!done1) begin
                if (state1 == S_EXEC_MD) begin
                    run1++;
                    md1 += int'(md_start1);
                end else if (run1 > 0) begin
                    done1 = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        checkVal("md1_cycles", run1, 1);
        checkVal("md1_pulses", md1, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random instruction stream against the reference model.
        ops = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL,
                OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, 6'h3f, 6'h20};
        fns = '{FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU, FN_SLL,
                FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_MULT, FN_MULTU, FN_DIV,
                FN_DIVU, FN_JR, FN_ADD, FN_SUB};
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(0, ops.size() - 1)];
            fn = fns[$urandom_range(0, fns.size() - 1)];
            runInstr(op, fn, 1'($urandom), ($urandom_range(0, 7) == 0),
                     $urandom_range(0, 2), $urandom_range(0, 3), halted);
            if (halted) begin
                for (int i = 0; i < 3; i++)
                    stepCheck(model(S_HALT, op, fn, 1'b0, 1'b0, 1'b0), "rand_halt");
                doReset(S_HALT);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
